vdp_sprite_writer: RTL and testbench

//  Write-side master for the VDP sprite register port (xy_we / row_we / wr_row_index / wr_data).
//  On a load pulse, uploads an 8x8 ERGB image plus an XY/control word into one sprite.

---
 rtl/vdp_sprite_writer_pkg.sv | 31 +++
 rtl/vdp_sprite_writer_if.sv | 20 ++
 rtl/vdp_sprite_writer_axis_bounce.sv | 33 +++
 rtl/vdp_sprite_writer.sv | 178 +++++++++++++++++
 tb/tb_vdp_sprite_writer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_sprite_writer_pkg.sv
// Shared VDP sprite-port definitions: row/XY word layout, FSM states and the XY word builder.
package vdp_sprite_writer_pkg;

    localparam int ROW_W         = 32;
    localparam int ROW_IDX_W     = 3;
    localparam int XY_FIELD_W    = 10;
    localparam int XY_ENABLE_BIT = 31;
    localparam int XY_TILE_BIT   = 30;
    localparam int XY_X_LSB      = 10;
    localparam int XY_Y_LSB      = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_ROW = 3'd1,
        ST_LOAD_XY  = 3'd2,
        ST_CALC     = 3'd3,
        ST_MOVE_XY  = 3'd4
    } state_e;

    function automatic logic [ROW_W-1:0] xy_word(input logic [XY_FIELD_W-1:0] x,
                                                 input logic [XY_FIELD_W-1:0] y);
        logic [ROW_W-1:0] w;
        w = '0;
        w[XY_ENABLE_BIT] = 1'b1;
        w[XY_TILE_BIT] = 1'b0;
        w[XY_X_LSB +: XY_FIELD_W] = x;
        w[XY_Y_LSB +: XY_FIELD_W] = y;
        return w;
    endfunction

endpackage

// File: rtl/vdp_sprite_writer_if.sv
// Write side of the VDP sprite register port: strobes, row index, data and the ready handshake.
interface vdp_sprite_writer_if;
    import vdp_sprite_writer_pkg::*;

    logic                 xy_we;
    logic                 row_we;
    logic [ROW_IDX_W-1:0] wr_row_index;
    logic [ROW_W-1:0]     wr_data;
    logic                 wr_ready;

    modport master (
        output xy_we, row_we, wr_row_index, wr_data,
        input  wr_ready
    );

    modport slave (
        input  xy_we, row_we, wr_row_index, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vdp_sprite_writer_axis_bounce.sv
// One axis of sprite motion: adds a signed velocity and reflects off [0, limit].
module vdp_sprite_writer_axis_bounce #(
    parameter int POS_W = 10,
    parameter int VEL_W = 2
) (
    input  logic        [POS_W-1:0] pos_i,
    input  logic signed [VEL_W-1:0] vel_i,
    input  logic        [POS_W-1:0] limit_i,
    output logic        [POS_W-1:0] pos_o,
    output logic signed [VEL_W-1:0] vel_o
);
    localparam int SUM_W = POS_W + 2;
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

    logic signed [SUM_W-1:0] sum;
    logic signed [VEL_W-1:0] vel_neg;

    always_comb begin
        sum = $signed({2'b00, pos_i}) + $signed({{(SUM_W-VEL_W){vel_i[VEL_W-1]}}, vel_i});
        // The most negative velocity has no positive twin; clamp it instead of wrapping.
        vel_neg = (vel_i == VEL_MIN) ? VEL_MAX : -vel_i;
        pos_o = sum[POS_W-1:0];
        vel_o = vel_i;
        if (sum < 0) begin
            pos_o = '0;
            vel_o = vel_neg;
        end else if (sum > $signed({2'b00, limit_i})) begin
            pos_o = limit_i;
            vel_o = vel_neg;
        end
    end
endmodule

// File: rtl/vdp_sprite_writer.sv
// Sprite write master: uploads an 8x8 image + XY word on load, then bounces the sprite once per frame.
module vdp_sprite_writer
    import vdp_sprite_writer_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          SPRITE_WIDTH  = 8,
    parameter int          SPRITE_HEIGHT = 8,
    parameter int          X_WIDTH       = 10,
    parameter int          Y_WIDTH       = 10,
    parameter int          DX_WIDTH      = 2,
    parameter int          DY_WIDTH      = 2,
    parameter int          X0            = 0,
    parameter int          Y0            = 0,
    parameter int          DX0           = 1,
    parameter int          DY0           = 1,
    parameter logic [31:0] ROW_0         = 32'h0,
    parameter logic [31:0] ROW_1         = 32'h0,
    parameter logic [31:0] ROW_2         = 32'h0,
    parameter logic [31:0] ROW_3         = 32'h0,
    parameter logic [31:0] ROW_4         = 32'h0,
    parameter logic [31:0] ROW_5         = 32'h0,
    parameter logic [31:0] ROW_6         = 32'h0,
    parameter logic [31:0] ROW_7         = 32'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                frame_start,
    input  logic                motion_en,
    vdp_sprite_writer_if.master wr,
    output logic                busy,
    output logic [X_WIDTH-1:0]  x_out,
    output logic [Y_WIDTH-1:0]  y_out
);
    localparam logic        [X_WIDTH-1:0]  X_INIT  = X_WIDTH'(X0);
    localparam logic        [Y_WIDTH-1:0]  Y_INIT  = Y_WIDTH'(Y0);
    localparam logic signed [DX_WIDTH-1:0] DX_INIT = DX_WIDTH'(DX0);
    localparam logic signed [DY_WIDTH-1:0] DY_INIT = DY_WIDTH'(DY0);
    localparam logic        [X_WIDTH-1:0]  X_LIMIT = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
    localparam logic        [Y_WIDTH-1:0]  Y_LIMIT = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);

    state_e                      state_q;
    logic [ROW_IDX_W-1:0]        idx_q;
    logic                        xy_we_q, row_we_q, busy_q;
    logic [ROW_W-1:0]            data_q;
    logic [X_WIDTH-1:0]          x_q, x_d;
    logic [Y_WIDTH-1:0]          y_q, y_d;
    logic signed [DX_WIDTH-1:0]  dx_q, dx_d;
    logic signed [DY_WIDTH-1:0]  dy_q, dy_d;
    logic                        pend_load_q, pend_load_d;
    logic                        pend_frame_q, pend_frame_d;
    logic                        xfer, frame_ev;

    function automatic logic [ROW_W-1:0] row_word(input logic [ROW_IDX_W-1:0] i);
        case (i)
            3'd0:    return ROW_0;
            3'd1:    return ROW_1;
            3'd2:    return ROW_2;
            3'd3:    return ROW_3;
            3'd4:    return ROW_4;
            3'd5:    return ROW_5;
            3'd6:    return ROW_6;
            default: return ROW_7;
        endcase
    endfunction

    vdp_sprite_writer_axis_bounce #(.POS_W(X_WIDTH), .VEL_W(DX_WIDTH)) u_bounce_x (
        .pos_i(x_q), .vel_i(dx_q), .limit_i(X_LIMIT), .pos_o(x_d), .vel_o(dx_d)
    );

    vdp_sprite_writer_axis_bounce #(.POS_W(Y_WIDTH), .VEL_W(DY_WIDTH)) u_bounce_y (
        .pos_i(y_q), .vel_i(dy_q), .limit_i(Y_LIMIT), .pos_o(y_d), .vel_o(dy_d)
    );

    assign xfer     = (xy_we_q | row_we_q) & wr.wr_ready;
    assign frame_ev = frame_start & motion_en;

    // One-deep pending requests; a finished load discards any step queued before it.
    always_comb begin
        pend_load_d  = pend_load_q;
        pend_frame_d = pend_frame_q;
        if (state_q == ST_IDLE) begin
            if (load || pend_load_q) begin
                pend_load_d = 1'b0;
                if (frame_ev) pend_frame_d = 1'b1;
            end else begin
                pend_frame_d = 1'b0;
            end
        end else begin
            if (load)     pend_load_d  = 1'b1;
            if (frame_ev) pend_frame_d = 1'b1;
        end
        if (state_q == ST_LOAD_XY && xfer) pend_frame_d = 1'b0;
        if (!motion_en)                    pend_frame_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            xy_we_q      <= 1'b0;
            row_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= '0;
            x_q          <= X_INIT;
            y_q          <= Y_INIT;
            dx_q         <= DX_INIT;
            dy_q         <= DY_INIT;
            pend_load_q  <= 1'b0;
            pend_frame_q <= 1'b0;
        end else begin
            pend_load_q  <= pend_load_d;
            pend_frame_q <= pend_frame_d;
            case (state_q)
                ST_IDLE: begin
                    if (load || pend_load_q) begin
                        state_q  <= ST_LOAD_ROW;
                        idx_q    <= '0;
                        row_we_q <= 1'b1;
                        data_q   <= row_word('0);
                        busy_q   <= 1'b1;
                    end else if (frame_ev || pend_frame_q) begin
                        state_q <= ST_CALC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD_ROW: begin
                    if (xfer) begin
                        if (idx_q == 3'd7) begin
                            state_q  <= ST_LOAD_XY;
                            row_we_q <= 1'b0;
                            xy_we_q  <= 1'b1;
                            x_q      <= X_INIT;
                            y_q      <= Y_INIT;
                            dx_q     <= DX_INIT;
                            dy_q     <= DY_INIT;
                            data_q   <= xy_word(XY_FIELD_W'(X_INIT), XY_FIELD_W'(Y_INIT));
                        end else begin
                            idx_q  <= idx_q + 3'd1;
                            data_q <= row_word(idx_q + 3'd1);
                        end
                    end
                end
                ST_CALC: begin
                    state_q <= ST_MOVE_XY;
                    x_q     <= x_d;
                    y_q     <= y_d;
                    dx_q    <= dx_d;
                    dy_q    <= dy_d;
                    xy_we_q <= 1'b1;
                    data_q  <= xy_word(XY_FIELD_W'(x_d), XY_FIELD_W'(y_d));
                end
                ST_LOAD_XY, ST_MOVE_XY: begin
                    if (xfer) begin
                        state_q <= ST_IDLE;
                        xy_we_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    xy_we_q  <= 1'b0;
                    row_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wr.xy_we        = xy_we_q;
    assign wr.row_we       = row_we_q;
    assign wr.wr_row_index = idx_q;
    assign wr.wr_data      = data_q;
    assign busy            = busy_q;
    assign x_out           = x_q;
    assign y_out           = y_q;
endmodule

// File: tb/tb_vdp_sprite_writer.sv
// Bench for vdp_sprite_writer: directed load/motion scenarios plus random ready and random events vs a position model.
`timescale 1ns/1ps
module tb_vdp_sprite_writer;
    localparam int XI = 630;
    localparam int YI = 0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic       frame_start = 1'b0;
    logic       motion_en = 1'b1;
    logic       busy;
    logic [9:0] x_out, y_out;
    int         rdy_mode = 1;
    int         n_cmp = 0;
    int         n_bad = 0;

    vdp_sprite_writer_if bus();

    vdp_sprite_writer #(
        .X0(XI), .Y0(YI), .DX0(1), .DY0(-1),
        .ROW_0(32'h8888_8888), .ROW_1(32'h9ABC_DEF0), .ROW_2(32'h1234_5678), .ROW_3(32'hFEDC_BA98),
        .ROW_4(32'h0F0F_0F0F), .ROW_5(32'hF0F0_F0F0), .ROW_6(32'h8421_8421), .ROW_7(32'hC3C3_C3C3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .frame_start(frame_start), .motion_en(motion_en),
        .wr(bus), .busy(busy), .x_out(x_out), .y_out(y_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Ready is changed shortly after each rising edge so it is stable for the next transfer edge.
    initial bus.wr_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.wr_ready = 1'b0;
            1:       bus.wr_ready = 1'b1;
            2:       bus.wr_ready = ~bus.wr_ready;
            default: bus.wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic [31:0] exp_row(input int i);
        case (i)
            0: return 32'h8888_8888;
            1: return 32'h9ABC_DEF0;
            2: return 32'h1234_5678;
            3: return 32'hFEDC_BA98;
            4: return 32'h0F0F_0F0F;
            5: return 32'hF0F0_F0F0;
            6: return 32'h8421_8421;
            default: return 32'hC3C3_C3C3;
        endcase
    endfunction

    function automatic logic [31:0] exp_xy(input int x, input int y);
        return 32'h8000_0000 | (32'(x) << 10) | 32'(y);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sprite position model: plain integer arithmetic with reflection at the screen edges.
    int mx, my, mdx, mdy;

    function automatic int neg_vel(input int v);
        return (v == -2) ? 1 : -v;
    endfunction

    task automatic model_load();
        mx = XI; my = YI; mdx = 1; mdy = -1;
    endtask

    task automatic model_step();
        int nx, ny;
        nx = mx + mdx;
        ny = my + mdy;
        if (nx < 0) begin mx = 0; mdx = neg_vel(mdx); end
        else if (nx > 640 - 8) begin mx = 640 - 8; mdx = neg_vel(mdx); end
        else mx = nx;
        if (ny < 0) begin my = 0; mdy = neg_vel(mdy); end
        else if (ny > 480 - 8) begin my = 480 - 8; mdy = neg_vel(mdy); end
        else my = ny;
    endtask

    // Transfer log and handshake-stability monitor.
    typedef struct {
        bit          is_xy;
        logic [2:0]  idx;
        logic [31:0] data;
    } xfer_t;
    xfer_t       log_q[$];
    logic        pend_prev = 1'b0;
    logic [4:0]  ctl_prev;
    logic [31:0] data_prev;

    always @(negedge clk) begin
        #1;
        chk("one_strobe", 32'(bus.xy_we & bus.row_we), 32'd0);
        if (pend_prev) begin
            chk("hold_ctl", 32'({bus.xy_we, bus.row_we, bus.wr_row_index}), 32'(ctl_prev));
            chk("hold_data", bus.wr_data, data_prev);
        end
        if (reset_n && (bus.xy_we || bus.row_we) && bus.wr_ready)
            log_q.push_back('{is_xy: bus.xy_we, idx: bus.wr_row_index, data: bus.wr_data});
        pend_prev = reset_n && (bus.xy_we || bus.row_we) && !bus.wr_ready;
        ctl_prev  = {bus.xy_we, bus.row_we, bus.wr_row_index};
        data_prev = bus.wr_data;
    end

    task automatic pulse(input bit l, input bit f);
        load = l;
        frame_start = f;
        @(negedge clk);
        load = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 500) begin
            @(negedge clk);
            n++;
            if (busy) quiet = 0; else quiet++;
        end
        chk({tag, "_timeout"}, 32'(n >= 500), 32'd0);
    endtask

    task automatic check_load_log(input string tag);
        chk({tag, "_count"}, 32'(log_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < int'(log_q.size()); i++) begin
            if (i < 8) begin
                chk({tag, "_row_kind"}, 32'(log_q[i].is_xy), 32'd0);
                chk({tag, "_row_idx"}, 32'(log_q[i].idx), 32'(i));
                chk({tag, "_row_data"}, log_q[i].data, exp_row(i));
            end else begin
                chk({tag, "_xy_kind"}, 32'(log_q[i].is_xy), 32'd1);
                chk({tag, "_xy_data"}, log_q[i].data, exp_xy(XI, YI));
            end
        end
        log_q.delete();
    endtask

    task automatic check_moves(input string tag, input int steps);
        chk({tag, "_count"}, 32'(log_q.size()), 32'(steps));
        for (int i = 0; i < steps; i++) begin
            model_step();
            if (i < int'(log_q.size())) begin
                chk({tag, "_kind"}, 32'(log_q[i].is_xy), 32'd1);
                chk({tag, "_data"}, log_q[i].data, exp_xy(mx, my));
            end
        end
        chk({tag, "_x"}, 32'(x_out), 32'(mx));
        chk({tag, "_y"}, 32'(y_out), 32'(my));
        log_q.delete();
    endtask

    initial begin
        int xs[4] = '{631, 632, 632, 631};
        int ys[4] = '{0, 1, 2, 3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_row_we", 32'(bus.row_we), 32'd0);
        chk("rst_xy_we", 32'(bus.xy_we), 32'd0);
        chk("rst_idx", 32'(bus.wr_row_index), 32'd0);
        chk("rst_data", bus.wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_x", 32'(x_out), 32'(XI));
        chk("rst_y", 32'(y_out), 32'(YI));
        reset_n = 1'b1;
        @(negedge clk);
        log_q.delete();

        // Load with ready tied high: cycle-exact row sequence and busy window
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("t1_row_we", 32'(bus.row_we), 32'd1);
            chk("t1_idx", 32'(bus.wr_row_index), 32'(k));
            chk("t1_data", bus.wr_data, exp_row(k));
            chk("t1_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("t1_xy_we", 32'(bus.xy_we), 32'd1);
        chk("t1_xy_row_we", 32'(bus.row_we), 32'd0);
        chk("t1_xy_data", bus.wr_data, 32'h8009_D800);
        chk("t1_xy_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_xy_end", 32'(bus.xy_we), 32'd0);
        check_load_log("t1");
        model_load();

        // Load with ready toggling
        rdy_mode = 2;
        pulse(1'b1, 1'b0);
        wait_quiet("t2");
        check_load_log("t2");
        model_load();
        rdy_mode = 1;
        @(negedge clk);

        // Right-edge and top-edge bounce, frame latency
        for (int k = 0; k < 4; k++) begin
            pulse(1'b0, 1'b1);
            if (k == 0) begin
                chk("t3_calc_xy_we", 32'(bus.xy_we), 32'd0);
                chk("t3_calc_busy", 32'(busy), 32'd1);
                @(negedge clk);
                chk("t3_lat_xy_we", 32'(bus.xy_we), 32'd1);
            end
            wait_quiet("t3");
            chk("t3_x", 32'(x_out), 32'(xs[k]));
            chk("t3_y", 32'(y_out), 32'(ys[k]));
            chk("t3_count", 32'(log_q.size()), 32'd1);
            if (log_q.size() > 0) chk("t3_data", log_q[0].data, exp_xy(xs[k], ys[k]));
            log_q.delete();
            model_step();
        end

        // Frame during load is dropped; two frames during MOVE_XY give one extra step
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b1);
        wait_quiet("t4a");
        check_load_log("t4a");
        model_load();
        chk("t4a_x", 32'(x_out), 32'(XI));
        rdy_mode = 0;
        pulse(1'b0, 1'b1);
        @(negedge clk);
        chk("t4_move_stall", 32'(bus.xy_we), 32'd1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        rdy_mode = 1;
        wait_quiet("t4b");
        check_moves("t4b", 2);

        // Load and frame together: load only; motion disabled: no write
        pulse(1'b1, 1'b1);
        wait_quiet("t5a");
        check_load_log("t5a");
        model_load();
        chk("t5a_x", 32'(x_out), 32'(XI));
        chk("t5a_y", 32'(y_out), 32'(YI));
        motion_en = 1'b0;
        pulse(1'b0, 1'b1);
        wait_quiet("t5b");
        chk("t5b_count", 32'(log_q.size()), 32'd0);
        chk("t5b_busy", 32'(busy), 32'd0);
        log_q.delete();
        motion_en = 1'b1;

        // Reset in the middle of a load, then a fresh load
        pulse(1'b0, 1'b1);
        wait_quiet("t6pre");
        check_moves("t6pre", 1);
        pulse(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_mid_idx", 32'(bus.wr_row_index), 32'd4);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_row_we", 32'(bus.row_we), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_x", 32'(x_out), 32'(XI));
        chk("t6_y", 32'(y_out), 32'(YI));
        reset_n = 1'b1;
        log_q.delete();
        model_load();
        @(negedge clk);
        pulse(1'b1, 1'b0);
        chk("t6_restart_idx", 32'(bus.wr_row_index), 32'd0);
        chk("t6_restart_data", bus.wr_data, exp_row(0));
        wait_quiet("t6");
        check_load_log("t6");

        // Random ready and random event mix against the model
        rdy_mode = 3;
        for (int it = 0; it < 40; it++) begin
            int op = int'($urandom_range(0, 9));
            if (op == 0) begin
                pulse(1'b1, 1'b0);
                wait_quiet("rnd_load");
                check_load_log("rnd_load");
                model_load();
            end else if (op == 1) begin
                motion_en = 1'b0;
                pulse(1'b0, 1'b1);
                wait_quiet("rnd_off");
                chk("rnd_off_count", 32'(log_q.size()), 32'd0);
                log_q.delete();
                motion_en = 1'b1;
            end else begin
                pulse(1'b0, 1'b1);
                wait_quiet("rnd_step");
                check_moves("rnd_step", 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
